// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle RV32I core: sequences IF/ID/EX/MEM/WB over the shared ALU and memory.
// Optional build macro MC_CTRL_PERF_CNT_EN adds cycle_count / retire_count outputs.
module multicycle_control_unit #(
   parameter logic [2:0] RESET_STATE = 3'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  opcode,
   input  logic        mem_ready,
   input  logic        halt_cond,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic [1:0]  pc_source,
   output logic        i_or_d,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        reg_write,
   output logic [1:0]  mem_to_reg,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op_sel,
   output logic        is_halted,
   output logic [2:0]  state
`ifdef MC_CTRL_PERF_CNT_EN
   ,
   output logic [31:0] cycle_count,
   output logic [31:0] retire_count
`endif
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_ECALL  = 7'b1110011;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_e;

   state_e state_q, state_d;

   logic pc_write_raw, pc_write_cond_raw, ir_write_raw, reg_write_raw, mem_write_raw;

   always_ff @(posedge clk) begin
      if (reset) state_q <= state_e'(RESET_STATE);
      else       state_q <= state_d;
   end

   always_comb begin
      state_d           = state_q;
      pc_write_raw      = 1'b0;
      pc_write_cond_raw = 1'b0;
      ir_write_raw      = 1'b0;
      reg_write_raw     = 1'b0;
      mem_write_raw     = 1'b0;
      pc_source         = 2'b00;
      i_or_d            = 1'b0;
      mem_read          = 1'b0;
      mem_to_reg        = 2'b00;
      alu_src_a         = 2'b00;
      alu_src_b         = 2'b00;
      alu_op_sel        = 2'b00;
      is_halted         = 1'b0;

      case (state_q)
         S_IF: begin
            // PC <= PC + 4 and IR latch both commit on the same ready cycle
            mem_read     = 1'b1;
            alu_src_b    = 2'b01;
            ir_write_raw = mem_ready;
            pc_write_raw = mem_ready;
            if (mem_ready) state_d = S_ID;
         end
         S_ID: begin
            // ALUOut captures old_pc + imm, the branch/JAL target used in EX
            alu_src_a = 2'b10;
            alu_src_b = 2'b10;
            case (opcode)
               OP_ECALL: state_d = halt_cond ? S_HALT : S_IF;
               OP_R, OP_IMM, OP_LOAD, OP_STORE,
               OP_BRANCH, OP_JAL, OP_JALR: state_d = S_EX;
               default: state_d = S_IF;
            endcase
         end
         S_EX: begin
            state_d = S_IF;
            case (opcode)
               OP_R: begin
                  alu_src_a  = 2'b01;
                  alu_src_b  = 2'b00;
                  alu_op_sel = 2'b10;
                  state_d    = S_WB;
               end
               OP_IMM: begin
                  alu_src_a  = 2'b01;
                  alu_src_b  = 2'b10;
                  alu_op_sel = 2'b10;
                  state_d    = S_WB;
               end
               OP_LOAD, OP_STORE: begin
                  alu_src_a = 2'b01;
                  alu_src_b = 2'b10;
                  state_d   = S_MEM;
               end
               OP_BRANCH: begin
                  alu_src_a         = 2'b01;
                  alu_src_b         = 2'b00;
                  alu_op_sel        = 2'b01;
                  pc_write_cond_raw = 1'b1;
                  pc_source         = 2'b01;
               end
               OP_JAL: begin
                  // PC already holds old_pc + 4, which becomes the link value
                  pc_write_raw  = 1'b1;
                  pc_source     = 2'b01;
                  reg_write_raw = 1'b1;
                  mem_to_reg    = 2'b10;
               end
               OP_JALR: begin
                  alu_src_a     = 2'b01;
                  alu_src_b     = 2'b10;
                  pc_write_raw  = 1'b1;
                  pc_source     = 2'b10;
                  reg_write_raw = 1'b1;
                  mem_to_reg    = 2'b10;
               end
               default: state_d = S_IF;
            endcase
         end
         S_MEM: begin
            i_or_d        = 1'b1;
            mem_read      = (opcode == OP_LOAD);
            mem_write_raw = (opcode == OP_STORE);
            if (mem_ready) state_d = (opcode == OP_LOAD) ? S_WB : S_IF;
         end
         S_WB: begin
            reg_write_raw = 1'b1;
            mem_to_reg    = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
            state_d       = S_IF;
         end
         S_HALT: begin
            is_halted = 1'b1;
         end
         default: state_d = S_IF;
      endcase
   end

   // Reset suppresses every architectural write, abandoning any pending access
   assign pc_write      = pc_write_raw      & ~reset;
   assign pc_write_cond = pc_write_cond_raw & ~reset;
   assign ir_write      = ir_write_raw      & ~reset;
   assign reg_write     = reg_write_raw     & ~reset;
   assign mem_write     = mem_write_raw     & ~reset;
   assign state         = state_q;

`ifdef MC_CTRL_PERF_CNT_EN
   logic [31:0] cycle_q, cycle_d, retire_q, retire_d;
   logic        retire_evt;

   assign retire_evt = ((state_d == S_IF) &&
                        (state_q inside {S_ID, S_EX, S_MEM, S_WB})) ||
                       ((state_d == S_HALT) && (state_q != S_HALT));

   always_comb begin
      cycle_d  = cycle_q;
      retire_d = retire_q;
      if (state_q != S_HALT) cycle_d = cycle_q + 32'd1;
      if (retire_evt)        retire_d = retire_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_q  <= 32'd0;
         retire_q <= 32'd0;
      end else begin
         cycle_q  <= cycle_d;
         retire_q <= retire_d;
      end
   end

   assign cycle_count  = cycle_q;
   assign retire_count = retire_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench for multicycle_control_unit against an instruction-level path model.
module tb_multicycle_control_unit;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_ECALL  = 7'b1110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] opcode = 7'd0;
   logic       mem_ready = 1'b0;
   logic       halt_cond = 1'b0;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
   logic       ir_write, reg_write, is_halted;
   logic [1:0] pc_source, mem_to_reg, alu_src_a, alu_src_b, alu_op_sel;
   logic [2:0] state;
`ifdef MC_CTRL_PERF_CNT_EN
   logic [31:0] cycle_count, retire_count;
`endif

   multicycle_control_unit dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .halt_cond(halt_cond), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
      .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op_sel(alu_op_sel), .is_halted(is_halted), .state(state)
`ifdef MC_CTRL_PERF_CNT_EN
      , .cycle_count(cycle_count), .retire_count(retire_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int   st;
      logic mr;
   } step_t;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_cyc  = 0;
   int exp_ret  = 0;
   int cur_st   = 0;

   logic [17:0] ctrl_vec;
   assign ctrl_vec = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                      ir_write, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op_sel,
                      is_halted};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected control word for one cycle, straight from the per-state output table.
   function automatic logic [17:0] exp_ctrl(input int st, input logic [6:0] op,
                                            input logic mr, input logic rst);
      logic pcw, pcwc, iod, mrd, mwr, irw, rw, hlt;
      logic [1:0] pcs, m2r, sa, sb, aop;
      {pcw, pcwc, iod, mrd, mwr, irw, rw, hlt} = '0;
      {pcs, m2r, sa, sb, aop} = '0;
      case (st)
         0: begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
         1: begin sa = 2'b10; sb = 2'b10; end
         2: case (op)
               OP_R:      begin sa = 2'b01; sb = 2'b00; aop = 2'b10; end
               OP_IMM:    begin sa = 2'b01; sb = 2'b10; aop = 2'b10; end
               OP_LOAD, OP_STORE: begin sa = 2'b01; sb = 2'b10; end
               OP_BRANCH: begin sa = 2'b01; sb = 2'b00; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
               OP_JAL:    begin pcw = 1; pcs = 2'b01; rw = 1; m2r = 2'b10; end
               OP_JALR:   begin sa = 2'b01; sb = 2'b10; pcw = 1; pcs = 2'b10; rw = 1; m2r = 2'b10; end
               default: ;
            endcase
         3: begin iod = 1; mrd = (op == OP_LOAD); mwr = (op == OP_STORE); end
         4: begin rw = 1; m2r = (op == OP_LOAD) ? 2'b01 : 2'b00; end
         5: hlt = 1;
         default: ;
      endcase
      if (rst) {pcw, pcwc, irw, rw, mwr} = '0;
      return {pcw, pcwc, pcs, iod, mrd, mwr, irw, rw, m2r, sa, sb, aop, hlt};
   endfunction

   task automatic check_perf(input string tag);
`ifdef MC_CTRL_PERF_CNT_EN
      check({tag, "_cyc"}, cycle_count, 32'(exp_cyc));
      check({tag, "_ret"}, retire_count, 32'(exp_ret));
`else
      if (tag.len() < 0) $display("%s", tag);
`endif
   endtask

   // Hold reset for a number of cycles; write enables must stay low throughout.
   task automatic do_reset(input int cycles, input int st_before);
      for (int c = 0; c < cycles; c++) begin
         reset = 1'b1;
         mem_ready = 1'b1;
         @(negedge clk);
         check("rst_we", 32'({pc_write, pc_write_cond, ir_write, reg_write, mem_write}), 32'd0);
         if (c == 0 && st_before >= 0) check("rst_st_hold", 32'(state), 32'(st_before));
         if (c > 0) check("rst_state", 32'(state), 32'd0);
         @(posedge clk);
         #1;
         exp_cyc = 0;
         exp_ret = 0;
      end
      reset = 1'b0;
      cur_st = 0;
      check_perf("perf_rst");
   endtask

   // Build the cycle path of one instruction from its class, then walk it cycle by cycle.
   task automatic run_instr(input logic [6:0] op, input logic hc, input int if_stall,
                            input int mem_stall, input int abort_st);
      step_t q[$];
      for (int i = 0; i < if_stall; i++) q.push_back('{0, 1'b0});
      q.push_back('{0, 1'b1});
      q.push_back('{1, 1'($urandom_range(0, 1))});
      case (op)
         OP_ECALL: q.push_back('{hc ? 5 : 0, 1'b0});
         OP_R, OP_IMM: begin
            q.push_back('{2, 1'($urandom_range(0, 1))});
            q.push_back('{4, 1'($urandom_range(0, 1))});
            q.push_back('{0, 1'b0});
         end
         OP_LOAD, OP_STORE: begin
            q.push_back('{2, 1'($urandom_range(0, 1))});
            for (int i = 0; i < mem_stall; i++) q.push_back('{3, 1'b0});
            q.push_back('{3, 1'b1});
            if (op == OP_LOAD) q.push_back('{4, 1'($urandom_range(0, 1))});
            q.push_back('{0, 1'b0});
         end
         OP_BRANCH, OP_JAL, OP_JALR: begin
            q.push_back('{2, 1'($urandom_range(0, 1))});
            q.push_back('{0, 1'b0});
         end
         default: q.push_back('{0, 1'b0});
      endcase
      opcode = op;
      halt_cond = hc;
      for (int i = 0; i < q.size() - 1; i++) begin
         if (q[i].st == abort_st) begin
            do_reset(1 + $urandom_range(0, 1), abort_st);
            return;
         end
         mem_ready = q[i].mr;
         @(negedge clk);
         check("state", 32'(state), 32'(q[i].st));
         check("ctrl", 32'(ctrl_vec), 32'(exp_ctrl(q[i].st, op, q[i].mr, 1'b0)));
         @(posedge clk);
         if (q[i].st != 5) exp_cyc++;
         if ((q[i + 1].st == 0 && q[i].st >= 1 && q[i].st <= 4) ||
             (q[i + 1].st == 5 && q[i].st != 5)) exp_ret++;
         #1;
      end
      cur_st = q[q.size() - 1].st;
      check_perf("perf");
   endtask

   task automatic halt_hold(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         opcode = 7'($urandom);
         mem_ready = 1'($urandom_range(0, 1));
         halt_cond = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("halt_state", 32'(state), 32'd5);
         check("halt_ctrl", 32'(ctrl_vec), 32'(exp_ctrl(5, opcode, mem_ready, 1'b0)));
         @(posedge clk);
         #1;
      end
      check_perf("perf_halt");
   endtask

   logic [6:0] op_tab [9] = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                              OP_JAL, OP_JALR, OP_ECALL, OP_LUI};

   initial begin
      do_reset(2, -1);

      // Directed sequences from the test plan
      run_instr(OP_R, 1'b0, 0, 0, -1);
      run_instr(OP_LOAD, 1'b0, 0, 3, -1);
      run_instr(OP_BRANCH, 1'b0, 0, 0, -1);
      run_instr(OP_JALR, 1'b0, 0, 0, -1);
      run_instr(OP_JAL, 1'b0, 1, 0, -1);
      run_instr(OP_STORE, 1'b0, 2, 1, -1);
      run_instr(OP_ECALL, 1'b0, 0, 0, -1);
      run_instr(OP_LUI, 1'b0, 0, 0, -1);
      run_instr(OP_R, 1'b0, 2, 0, 0);
      run_instr(OP_STORE, 1'b0, 0, 2, 3);
      run_instr(OP_LOAD, 1'b0, 0, 2, 3);

      // Three ADDs then a halting ECALL from a clean reset
      do_reset(1, cur_st);
      for (int k = 0; k < 3; k++) run_instr(OP_R, 1'b0, 0, 0, -1);
      run_instr(OP_ECALL, 1'b1, 0, 0, -1);
      check("halt_reached", 32'(cur_st), 32'd5);
`ifdef MC_CTRL_PERF_CNT_EN
      check("perf_dir_cyc", cycle_count, 32'd14);
      check("perf_dir_ret", retire_count, 32'd4);
`endif
      halt_hold(10);
`ifdef MC_CTRL_PERF_CNT_EN
      check("perf_frz_cyc", cycle_count, 32'd14);
      check("perf_frz_ret", retire_count, 32'd4);
`endif
      do_reset(2, 5);

      // Randomized instruction stream
      for (int n = 0; n < 80; n++) begin
         logic [6:0] op;
         int abort_st;
         op = ($urandom_range(0, 9) == 9) ? 7'($urandom) : op_tab[$urandom_range(0, 8)];
         abort_st = -1;
         if ($urandom_range(0, 9) == 0) abort_st = ($urandom_range(0, 1) != 0) ? 3 : 0;
         run_instr(op, ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
                   $urandom_range(0, 3), abort_st);
         if (cur_st == 5) begin
            halt_hold(1 + $urandom_range(0, 4));
            do_reset(1 + $urandom_range(0, 1), 5);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore-style FSM that sequences the shared ALU, the register file and the unified instruction/data memory for the multicycle RV32I core.
- It steps each instruction through IF, ID, EX, MEM and WB using the opcode held in the instruction register.
- It drives mux selects and write-enables, and waits on memory through a ready handshake.
- `alu_control_unit` still decodes funct3/funct7 whenever `alu_op_sel` selects FUNCT mode.

Parameters:
- RESET_STATE, 3'd0 (IF): state entered on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; one clk edge with reset=1 returns FSM to IF
- opcode  input  7  IR[6:0], stable from ID onward
- mem_ready  input  1  memory has completed the current access this cycle
- halt_cond  input  1  ECALL halt condition (x17==10), computed by datapath
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load only if the ALU branch outcome (bcond) is 1
- pc_source  output  2  PC input: 00 ALU result, 01 ALUOut reg, 10 ALU result with bit0 cleared
- i_or_d  output  1  memory address: 0 PC, 1 ALUOut
- mem_read  output  1
- mem_write  output  1
- ir_write  output  1  latches IR, MDR and old_pc
- reg_write  output  1
- mem_to_reg  output  2  rd data: 00 ALUOut, 01 MDR, 10 PC
- alu_src_a  output  2  00 PC, 01 A (rs1 latch), 10 old_pc
- alu_src_b  output  2  00 B (rs2 latch), 01 const 4, 10 immediate
- alu_op_sel  output  2  00 ADD, 01 BRANCH (compare per funct3), 10 FUNCT (alu_control_unit)
- is_halted  output  1
- state  output  3  IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5

Behaviour:
- All outputs are 0 unless listed for a state. While reset=1, all write-enables (pc_write, pc_write_cond, ir_write, reg_write, mem_write) are forced to 0. State register resets to IF.
- IF: mem_read=1, i_or_d=0, src_a=PC, src_b=4, op ADD, pc_source=00. ir_write=mem_ready and pc_write=mem_ready. Stay in IF while mem_ready=0; go to ID when mem_ready=1.
- ID: src_a=old_pc, src_b=imm, op ADD, so ALUOut = branch/JAL target. Next state:
  - ECALL (1110011) with halt_cond=1 → HALT.
  - ECALL with halt_cond=0 → IF.
  - Unknown opcode → IF (NOP).
  - All other opcodes → EX.
- EX, by opcode:
  - R-type (0110011): src A/B, op FUNCT → WB.
  - I-arith (0010011): src A/imm, op FUNCT → WB.
  - LOAD (0000011) and STORE (0100011): src A/imm, op ADD → MEM.
  - BRANCH (1100011): src A/B, op BRANCH, pc_write_cond=1, pc_source=01 → IF.
  - JAL (1101111): pc_write=1, pc_source=01, reg_write=1, mem_to_reg=10 (PC already holds old_pc+4) → IF.
  - JALR (1100111): src A/imm, op ADD, pc_write=1, pc_source=10, reg_write=1, mem_to_reg=10 → IF.
- MEM: i_or_d=1. mem_read=1 for LOAD, mem_write=1 for STORE. Both are held until mem_ready. Stay in MEM while mem_ready=0. On mem_ready: LOAD → WB, STORE → IF.
- WB: reg_write=1. mem_to_reg=01 for LOAD, 00 otherwise → IF.
- HALT: is_halted=1, all enables 0. Leaves only on reset.
- Latency with mem_ready always 1: R/I-arith 4 cycles, LOAD 5, STORE 4, BRANCH/JAL/JALR 3, ECALL 2.
- Reset mid-MEM or mid-IF: the pending access is abandoned, no write occurs on the reset edge, and the next state is IF.

Optional Feature:
- MC_CTRL_PERF_CNT_EN. When defined, two extra 32-bit outputs are present:
  - cycle_count: increments every non-reset cycle while not in HALT.
  - retire_count: increments on each transition into IF from ID, EX, MEM or WB, and on entering HALT.
  - Both clear on reset and wrap from 0xFFFFFFFF to 0.
- When undefined, neither port nor counter logic exists.

Test Plan:
- Reset 2 cycles, then ADD (0110011), mem_ready=1 → states 0,1,2,4,0; reg_write=1 only in WB with mem_to_reg=00; alu_op_sel=10 in EX.
- LW with mem_ready low for 3 cycles in MEM → state stays 3 for 4 cycles, mem_read=1 and i_or_d=1 throughout, then WB with mem_to_reg=01. Total 8 cycles.
- BEQ → IF, ID, EX (pc_write_cond=1, pc_source=01, alu_op_sel=01), back to IF after 3 cycles; reg_write never 1.
- JALR → EX asserts pc_write=1, pc_source=10, reg_write=1, mem_to_reg=10 in the same cycle.
- ECALL with halt_cond=1 → HALT after ID, is_halted=1 and holds for 10 cycles. Reset → state 0, is_halted=0 next cycle.
- With MC_CTRL_PERF_CNT_EN: run 3 ADDs then halting ECALL, mem_ready=1 → retire_count=4, cycle_count=14, both frozen in HALT.
